// File: rtl/sel_mux_pipe.sv
// N:1 select mux with registered output, valid/ready handshake and a 2-entry skid buffer.
// Out-of-range selects emit DEFAULT_VAL, are flagged per beat and counted (saturating).
module sel_mux_pipe #(
  parameter int              WIDTH       = 32,
  parameter int              NUM_IN      = 8,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
  localparam int             SEL_W       = $clog2(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [SEL_W-1:0]        mux_sel_i,
  input  logic [NUM_IN*WIDTH-1:0] in_data_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [WIDTH-1:0]        out_data_o,
  output logic                    out_sel_err_o,
  output logic [15:0]             err_cnt_o,
  input  logic                    err_clr_i
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } beat_t;

  state_t      state_q, state_nxt;
  beat_t       main_q, skid_q, new_beat;
  logic        in_rdy_q;
  logic [15:0] err_cnt_q;
  logic        acc, pop;
  logic        ld_main_new, ld_main_skid, ld_skid;
  logic [SEL_W:0] sel_ext;

  assign acc = in_valid_i & in_rdy_q;
  assign pop = out_valid_o & out_ready_i;

  // One extra select bit keeps the range check and channel compare free of constant-width issues.
  assign sel_ext = {1'b0, mux_sel_i};

  always_comb begin
    new_beat.data = DEFAULT_VAL;
    new_beat.err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_ext == (SEL_W+1)'(k)) begin
        new_beat.data = in_data_i[k*WIDTH +: WIDTH];
        new_beat.err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      in_rdy_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      in_rdy_q <= (state_nxt != TWO);
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      EMPTY: if (acc) state_nxt = ONE;
      ONE: begin
        if (acc && !pop)      state_nxt = TWO;
        else if (!acc && pop) state_nxt = EMPTY;
      end
      TWO:   if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid_o  = (state_q != EMPTY);
    ld_main_new  = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      EMPTY: ld_main_new = acc;
      ONE: begin
        ld_main_new = acc & pop;
        ld_skid     = acc & ~pop;
      end
      TWO:   ld_main_skid = pop;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_new)       main_q <= new_beat;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= new_beat;
    end
  end

  // Clear takes effect before the same-cycle error count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= (acc && new_beat.err) ? 16'd1 : 16'd0;
    end else if (acc && new_beat.err && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign in_ready_o    = in_rdy_q;
  assign out_data_o    = main_q.data;
  assign out_sel_err_o = main_q.err;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: an 8-input instance (A) and a 5-input DEADBEEF-default instance (B).
module tb_sel_mux_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic          a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_err, a_clr;
  logic [2:0]    a_sel;
  logic [255:0]  a_in_data;
  logic [31:0]   a_out_data;
  logic [15:0]   a_cnt;

  logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err, b_clr;
  logic [2:0]    b_sel;
  logic [159:0]  b_in_data;
  logic [31:0]   b_out_data;
  logic [15:0]   b_cnt;

  sel_mux_pipe #(.WIDTH(32), .NUM_IN(8), .DEFAULT_VAL(32'h0)) u_a (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .mux_sel_i(a_sel), .in_data_i(a_in_data),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready),
    .out_data_o(a_out_data), .out_sel_err_o(a_err),
    .err_cnt_o(a_cnt), .err_clr_i(a_clr)
  );

  sel_mux_pipe #(.WIDTH(32), .NUM_IN(5), .DEFAULT_VAL(32'hDEAD_BEEF)) u_b (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .mux_sel_i(b_sel), .in_data_i(b_in_data),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .out_data_o(b_out_data), .out_sel_err_o(b_err),
    .err_cnt_o(b_cnt), .err_clr_i(b_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_in_valid = 0; a_out_ready = 1; a_clr = 0; a_sel = '0;
    b_in_valid = 0; b_out_ready = 1; b_clr = 0; b_sel = '0;
    for (int k = 0; k < 8; k++) a_in_data[k*32 +: 32] = 32'h1000_0000 + k;
    for (int k = 0; k < 5; k++) b_in_data[k*32 +: 32] = 32'h2000_0000 + k;

    // reset state and release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_err_cnt", {16'b0, a_cnt}, 32'd0);
    chk("rst_out_data", a_out_data, 32'd0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("rel_in_ready_pre", {31'b0, a_in_ready}, 32'd0);
    step();
    chk("rel_in_ready_post", {31'b0, a_in_ready}, 32'd1);
    chk("rel_out_valid", {31'b0, a_out_valid}, 32'd0);

    // streaming sel 0..7, latency 1
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1; a_sel = 3'(i);
      step();
      chk($sformatf("stream_data%0d", i), a_out_data, 32'h1000_0000 + i);
      chk($sformatf("stream_vld%0d", i), {31'b0, a_out_valid}, 32'd1);
    end
    a_in_valid = 0;
    step();
    chk("stream_drain", {31'b0, a_out_valid}, 32'd0);
    chk("stream_err_cnt", {16'b0, a_cnt}, 32'd0);

    // backpressure: A=ch1, B=ch2, C=ch3
    a_out_ready = 0;
    a_in_valid = 1; a_sel = 3'd1;
    step();
    chk("bp_A_head", a_out_data, 32'h1000_0001);
    a_sel = 3'd2;
    step();
    chk("bp_full_rdy", {31'b0, a_in_ready}, 32'd0);
    a_sel = 3'd3;
    step();
    chk("bp_C_held_rdy", {31'b0, a_in_ready}, 32'd0);
    chk("bp_A_stable", a_out_data, 32'h1000_0001);
    a_out_ready = 1;
    step();
    chk("bp_B_out", a_out_data, 32'h1000_0002);
    chk("bp_rdy_back", {31'b0, a_in_ready}, 32'd1);
    step();
    chk("bp_C_out", a_out_data, 32'h1000_0003);
    chk("bp_C_vld", {31'b0, a_out_valid}, 32'd1);
    a_in_valid = 0;
    step();
    chk("bp_empty", {31'b0, a_out_valid}, 32'd0);

    // out-of-range on the 5-input instance
    b_in_valid = 1; b_sel = 3'd4;
    step();
    chk("oor_in_range", b_out_data, 32'h2000_0004);
    chk("oor_in_range_err", {31'b0, b_err}, 32'd0);
    for (int s = 5; s < 8; s++) begin
      b_sel = 3'(s);
      step();
      chk($sformatf("oor_data_sel%0d", s), b_out_data, 32'hDEAD_BEEF);
      chk($sformatf("oor_err_sel%0d", s), {31'b0, b_err}, 32'd1);
    end
    chk("oor_cnt3", {16'b0, b_cnt}, 32'd3);
    b_clr = 1; b_sel = 3'd5;
    step();
    chk("oor_clr_with_err", {16'b0, b_cnt}, 32'd1);
    b_in_valid = 0;
    step();
    chk("oor_clr_alone", {16'b0, b_cnt}, 32'd0);
    b_clr = 0;

    // saturation
    b_in_valid = 1; b_sel = 3'd7;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat_reach", {16'b0, b_cnt}, 32'h0000_FFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("sat_hold", {16'b0, b_cnt}, 32'h0000_FFFF);
    b_in_valid = 0;
    step();

    // mid-stream reset in TWO
    a_out_ready = 0; a_in_valid = 1; a_sel = 3'd5;
    step();
    a_sel = 3'd6;
    step();
    chk("mrst_two", {31'b0, a_in_ready}, 32'd0);
    a_in_valid = 0;
    #2;
    rst = 1;
    #1;
    chk("mrst_vld_now", {31'b0, a_out_valid}, 32'd0);
    chk("mrst_data_now", a_out_data, 32'd0);
    chk("mrst_rdy_now", {31'b0, a_in_ready}, 32'd0);
    chk("mrst_b_cnt_now", {16'b0, b_cnt}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mrst_no_stale%0d", i), {31'b0, a_out_valid}, 32'd0);
    end
    a_in_valid = 1; a_sel = 3'd7;
    step();
    chk("mrst_fresh", a_out_data, 32'h1000_0007);
    a_in_valid = 0;
    step();
    chk("mrst_fresh_gone", {31'b0, a_out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
